wb_lsu_master: RTL and testbench



---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_lane_align.sv | 46 ++++
 rtl/wb_lsu_master.sv | 152 +++++++++++++++
 tb/tb_wb_lsu_master.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the Wishbone load/store initiator.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    RESP = 2'b10
  } lsu_state_e;

  localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;

  // Size 2'b11 is illegal and reported the same way as a misaligned access.
  function automatic logic lsu_bad_access(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store-side selects/replicated data and
// load-side shift, mask and sign/zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  st_sel_o,
  output logic [31:0] st_wdat_o,
  input  logic [31:0] ld_dat_i,
  input  logic [1:0]  ld_off_i,
  input  logic [1:0]  ld_size_i,
  input  logic        ld_unsigned_i,
  output logic [31:0] ld_rdata_o
);

  logic [31:0] ld_shifted;

  always_comb begin
    st_sel_o  = 4'b1111;
    st_wdat_o = st_wdata_i;
    case (st_size_i)
      SZ_BYTE: begin
        st_sel_o  = 4'b0001 << st_off_i;
        st_wdat_o = {4{st_wdata_i[7:0]}};
      end
      SZ_HALF: begin
        st_sel_o  = 4'b0011 << {st_off_i[1], 1'b0};
        st_wdat_o = {2{st_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_shifted = ld_dat_i >> {ld_off_i, 3'b000};
    ld_rdata_o = ld_shifted;
    case (ld_size_i)
      SZ_BYTE: ld_rdata_o = {{24{~ld_unsigned_i & ld_shifted[7]}}, ld_shifted[7:0]};
      SZ_HALF: ld_rdata_o = {{16{~ld_unsigned_i & ld_shifted[15]}}, ld_shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_lsu_master.sv
// Single-outstanding Wishbone classic initiator for core loads/stores; errors
// on misaligned/illegal size (response the cycle after acceptance) or bus timeout.
module wb_lsu_master
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [31:0] adr_o,
  output logic [3:0]  sel_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d, uns_q, uns_d, cyc_q, cyc_d, err_q, err_d;
  logic [1:0]  off_q, off_d, size_q, size_d;
  logic [31:0] adr_q, adr_d, dat_q, dat_d, rdata_q, rdata_d;
  logic [3:0]  sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]  st_sel;
  logic [31:0] st_wdat, ld_rdata;

  lsu_lane_align u_align (
    .st_size_i    (req_size_i),
    .st_off_i     (req_addr_i[1:0]),
    .st_wdata_i   (req_wdata_i),
    .st_sel_o     (st_sel),
    .st_wdat_o    (st_wdat),
    .ld_dat_i     (dat_i),
    .ld_off_i     (off_q),
    .ld_size_i    (size_q),
    .ld_unsigned_i(uns_q),
    .ld_rdata_o   (ld_rdata)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    uns_d   = uns_q;
    off_d   = off_q;
    size_d  = size_q;
    cyc_d   = cyc_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    cnt_inc = cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          we_d   = req_we_i;
          off_d  = req_addr_i[1:0];
          size_d = req_size_i;
          uns_d  = req_unsigned_i;
          if (lsu_bad_access(req_size_i, req_addr_i[1:0])) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end else begin
            cyc_d   = 1'b1;
            adr_d   = {req_addr_i[31:2], 2'b00};
            sel_d   = st_sel;
            dat_d   = st_wdat;
            cnt_d   = '0;
            state_d = BUS;
          end
        end
      end
      BUS: begin
        // ack takes priority over a timeout expiring in the same cycle
        if (ack_i) begin
          cyc_d   = 1'b0;
          err_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : ld_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
            cyc_d   = 1'b0;
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      off_q   <= '0;
      size_q  <= '0;
      cyc_q   <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      dat_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      size_q  <= size_d;
      cyc_q   <= cyc_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign cyc_o       = cyc_q;
  assign stb_o       = cyc_q;
  assign we_o        = we_q;
  assign adr_o       = adr_q;
  assign sel_o       = sel_q;
  assign dat_o       = dat_q;

endmodule

// File: tb/tb_wb_lsu_master.sv
// Bench for wb_lsu_master: directed vector table, randomized accesses against a
// byte-addressed memory model, timeout and asynchronous-reset sequences.
module tb_wb_lsu_master;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we, req_uns;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        cyc, stb, we;
  logic [31:0] adr, dout, din;
  logic [3:0]  sel;
  logic        ack;
  logic        ack_en;

  int checks = 0;
  int errors = 0;

  logic [31:0] smem [64];
  logic [7:0]  rmem [256];

  wb_lsu_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_size_i(req_size), .req_unsigned_i(req_uns),
    .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .cyc_o(cyc), .stb_o(stb), .we_o(we), .adr_o(adr),
    .sel_o(sel), .dat_o(dout), .dat_i(din), .ack_i(ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory slave: acks one cycle after it sees the strobe.
  assign din = smem[adr[7:2]];
  initial ack = 1'b0;
  always @(posedge clk) begin
    ack <= ack_en && cyc && stb && !ack;
    if (ack && cyc && we)
      for (int l = 0; l < 4; l++)
        if (sel[l]) smem[adr[7:2]][8*l +: 8] <= dout[8*l +: 8];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference: byte-addressed memory, little-endian assembly, arithmetic extension.
  function automatic void ref_access(input logic rw, input logic [31:0] a, input logic [1:0] sz,
                                     input logic u, input logic [31:0] wd,
                                     output logic [31:0] rd, output logic er,
                                     output logic [3:0] sl, output logic [31:0] dd);
    int n = 1 << sz;
    int off = int'(a % 4);
    longint v = 0;
    rd = '0; sl = '0; dd = '0;
    er = (sz == 2'd3) || (a % n != 0);
    if (er) return;
    for (int i = 0; i < 4; i++) dd[8*i +: 8] = wd[8*(i % n) +: 8];
    for (int i = 0; i < n; i++) sl[off + i] = 1'b1;
    if (rw) begin
      for (int i = 0; i < n; i++) rmem[a[7:0] + 8'(i)] = wd[8*i +: 8];
    end else begin
      for (int i = 0; i < n; i++) v += longint'(rmem[a[7:0] + 8'(i)]) << (8*i);
      if (!u && v >= (64'sd1 << (8*n - 1))) v -= (64'sd1 << (8*n));
      rd = 32'(v);
    end
  endfunction

  task automatic run_req(input logic rw, input logic [31:0] a, input logic [1:0] sz,
                         input logic u, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat,
                         output int ncyc, output logic [3:0] sl, output logic [31:0] dd);
    bit got = 0;
    lat = 0; ncyc = 0; sl = '0; dd = '0; rd = '0; er = 1'b0;
    @(negedge clk);
    chk("req_ready", {31'b0, req_ready}, 32'd1);
    req_we = rw; req_addr = a; req_size = sz; req_uns = u; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1; rd = rsp_rdata; er = rsp_err;
      end else begin
        if (cyc) begin ncyc++; sl = sel; dd = dout; end
        lat++;
      end
    end
    if (!got) chk("rsp_seen", 32'd0, 32'd1);
    else begin
      @(negedge clk);
      chk("rsp_pulse", {30'b0, rsp_valid, req_ready}, 32'd1);
    end
  endtask

  typedef struct {
    logic        rw;
    logic [31:0] a;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
    logic [3:0]  sl;
    logic [31:0] dd;
    int          lat;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [31:0] rd, mrd, mdd, w;
    logic [3:0]  sl, msl;
    logic        er, mer, rw, u;
    logic [31:0] dd, a;
    logic [1:0]  sz;
    int          lat, ncyc;

    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      for (int b = 0; b < 4; b++) rmem[4*i + b] = w[8*b +: 8];
      smem[i] <= w;
    end

    tbl[0]  = '{1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0, 4'b1111, 32'hDEADBEEF, 2};
    tbl[1]  = '{1'b0, 32'h10, 2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 4'b1111, 32'h0,        2};
    tbl[2]  = '{1'b1, 32'h20, 2'd2, 1'b0, 32'h1234ABCD, 32'h0,        1'b0, 4'b1111, 32'h1234ABCD, 2};
    tbl[3]  = '{1'b0, 32'h22, 2'd1, 1'b0, 32'h0,        32'h00001234, 1'b0, 4'b1100, 32'h0,        2};
    tbl[4]  = '{1'b1, 32'h23, 2'd0, 1'b0, 32'h00000080, 32'h0,        1'b0, 4'b1000, 32'h80808080, 2};
    tbl[5]  = '{1'b0, 32'h23, 2'd0, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0, 4'b1000, 32'h0,        2};
    tbl[6]  = '{1'b0, 32'h23, 2'd0, 1'b1, 32'h0,        32'h00000080, 1'b0, 4'b1000, 32'h0,        2};
    tbl[7]  = '{1'b0, 32'h20, 2'd1, 1'b0, 32'h0,        32'hFFFFABCD, 1'b0, 4'b0011, 32'h0,        2};
    tbl[8]  = '{1'b0, 32'h21, 2'd1, 1'b0, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        0};
    tbl[9]  = '{1'b1, 32'h22, 2'd2, 1'b0, 32'h55AA55AA, 32'h0,        1'b1, 4'b0000, 32'h0,        0};
    tbl[10] = '{1'b0, 32'h20, 2'd3, 1'b0, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        0};

    ack_en = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0; req_uns = 1'b0; req_wdata = '0;
    rst = 1'b1;
    #12;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_outs", {26'b0, rsp_valid, rsp_err, cyc, stb, we, |sel}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_adr_dat", adr | dout, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[k]) begin
      run_req(tbl[k].rw, tbl[k].a, tbl[k].sz, tbl[k].u, tbl[k].wd, rd, er, lat, ncyc, sl, dd);
      ref_access(tbl[k].rw, tbl[k].a, tbl[k].sz, tbl[k].u, tbl[k].wd, mrd, mer, msl, mdd);
      chk($sformatf("tbl%0d_rdata", k), rd, tbl[k].rd);
      chk($sformatf("tbl%0d_err", k), {31'b0, er}, {31'b0, tbl[k].er});
      chk($sformatf("tbl%0d_lat", k), 32'(lat), 32'(tbl[k].lat));
      chk($sformatf("tbl%0d_cyc", k), 32'(ncyc), tbl[k].er ? 32'd0 : 32'd2);
      if (!tbl[k].er) begin
        chk($sformatf("tbl%0d_sel", k), {28'b0, sl}, {28'b0, tbl[k].sl});
        if (tbl[k].rw) chk($sformatf("tbl%0d_dat", k), dd, tbl[k].dd);
      end
    end

    for (int k = 0; k < 150; k++) begin
      rw = 1'($urandom); u = 1'($urandom); sz = 2'($urandom_range(0, 3));
      a = 32'($urandom_range(0, 255)); w = $urandom;
      run_req(rw, a, sz, u, w, rd, er, lat, ncyc, sl, dd);
      ref_access(rw, a, sz, u, w, mrd, mer, msl, mdd);
      chk($sformatf("rnd%0d_rdata", k), rd, mrd);
      chk($sformatf("rnd%0d_err", k), {31'b0, er}, {31'b0, mer});
      chk($sformatf("rnd%0d_lat", k), 32'(lat), mer ? 32'd0 : 32'd2);
      chk($sformatf("rnd%0d_cyc", k), 32'(ncyc), mer ? 32'd0 : 32'd2);
      if (!mer) begin
        chk($sformatf("rnd%0d_sel", k), {28'b0, sl}, {28'b0, msl});
        chk($sformatf("rnd%0d_dat", k), dd, mdd);
      end
    end

    ack_en = 1'b0;
    run_req(1'b0, 32'h40, 2'd2, 1'b0, 32'h0, rd, er, lat, ncyc, sl, dd);
    chk("to_err", {31'b0, er}, 32'd1);
    chk("to_rdata", rd, 32'd0);
    chk("to_cyc", 32'(ncyc), 32'd8);
    chk("to_lat", 32'(lat), 32'd8);
    ack_en = 1'b1;
    run_req(1'b0, 32'h40, 2'd2, 1'b0, 32'h0, rd, er, lat, ncyc, sl, dd);
    ref_access(1'b0, 32'h40, 2'd2, 1'b0, 32'h0, mrd, mer, msl, mdd);
    chk("after_to_rdata", rd, mrd);
    chk("after_to_err", {31'b0, er}, 32'd0);

    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h44; req_size = 2'd2; req_uns = 1'b0; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("mid_cyc_up", {30'b0, cyc, stb}, 32'd3);
    #3 rst = 1'b1;
    #1 chk("mid_rst_cyc", {30'b0, cyc, stb}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_rsp", {31'b0, rsp_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rsp", {31'b0, rsp_valid}, 32'd0);
    chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
    run_req(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, rd, er, lat, ncyc, sl, dd);
    ref_access(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, mrd, mer, msl, mdd);
    chk("post_rst_rdata", rd, mrd);
    chk("post_rst_lat", 32'(lat), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
